iob_cache_iob_arbiter: RTL and testbench

Round-robin arbiter that shares one cache front-end IOb slave port between two IOb requesters, typically the instruction and data sides of a CPU. It sits directly in front of the cache top's iob_s port. It forwards one request at a time and locks the grant until that request is accepted. Read responses (rvalid/rdata) arrive in order, possibly several cycles later; an internal in-order ID FIFO routes each one back to the requester that issued the read.

---
 rtl/iob_cache_iob_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_iob_cache_iob_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_cache_iob_arbiter.sv
// Two-to-one round-robin IOb arbiter in front of the cache slave port.
// Grants lock until accepted; an in-order ID FIFO routes read responses back.
module iob_cache_iob_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int PEND_W = 2
) (
   input  logic                clk_i,
   input  logic                cke_i,
   input  logic                arst_i,

   input  logic                s0_iob_valid_i,
   input  logic [ADDR_W-1:0]   s0_iob_addr_i,
   input  logic [DATA_W-1:0]   s0_iob_wdata_i,
   input  logic [DATA_W/8-1:0] s0_iob_wstrb_i,
   output logic                s0_iob_ready_o,
   output logic                s0_iob_rvalid_o,
   output logic [DATA_W-1:0]   s0_iob_rdata_o,

   input  logic                s1_iob_valid_i,
   input  logic [ADDR_W-1:0]   s1_iob_addr_i,
   input  logic [DATA_W-1:0]   s1_iob_wdata_i,
   input  logic [DATA_W/8-1:0] s1_iob_wstrb_i,
   output logic                s1_iob_ready_o,
   output logic                s1_iob_rvalid_o,
   output logic [DATA_W-1:0]   s1_iob_rdata_o,

   output logic                m_iob_valid_o,
   output logic [ADDR_W-1:0]   m_iob_addr_o,
   output logic [DATA_W-1:0]   m_iob_wdata_o,
   output logic [DATA_W/8-1:0] m_iob_wstrb_o,
   input  logic                m_iob_ready_i,
   input  logic                m_iob_rvalid_i,
   input  logic [DATA_W-1:0]   m_iob_rdata_i,

   output logic [PEND_W:0]     pending_o,
   output logic                err_o,
   output logic [1:0]          dbg_state_o
);

   // Handshake: a request transfers in any cycle where m_iob_valid_o and
   // m_iob_ready_i are both high; requesters hold valid/payload until ready.

   localparam int DEPTH = 2 ** PEND_W;
   localparam logic [PEND_W:0] FULL_CNT = (PEND_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      ST_FREE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2
   } lock_state_t;

   lock_state_t r_state;
   lock_state_t w_state_nxt;
   logic        r_last_grant;

   logic        w_locked;
   logic        w_owner;
   logic        w_grant;
   logic        w_any;
   logic        w_is_read;
   logic        w_fifo_full;
   logic        w_fifo_empty;
   logic        w_block;
   logic        w_m_valid;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;
   logic        w_head;
   logic        w_rv0;
   logic        w_rv1;

   logic             r_id_mem [DEPTH];
   logic [PEND_W-1:0] r_wptr;
   logic [PEND_W-1:0] r_rptr;
   logic [PEND_W:0]   r_count;
   logic              r_err;

   // Lock FSM: state register
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state <= ST_FREE;
      end else if (cke_i) begin
         r_state <= w_state_nxt;
      end
   end

   // Lock FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      if (w_m_valid && !m_iob_ready_i) begin
         w_state_nxt = w_grant ? ST_LOCK1 : ST_LOCK0;
      end else if (w_accept) begin
         w_state_nxt = ST_FREE;
      end
   end

   // Lock FSM: outputs
   always_comb begin
      w_locked    = (r_state != ST_FREE);
      w_owner     = (r_state == ST_LOCK1);
      dbg_state_o = r_state;
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_last_grant <= 1'b1;
      end else if (cke_i && w_accept) begin
         r_last_grant <= w_grant;
      end
   end

   // Grant selection; a locked owner wins regardless of the other side
   always_comb begin
      w_grant = 1'b0;
      w_any   = 1'b0;
      if (w_locked) begin
         w_grant = w_owner;
         w_any   = w_owner ? s1_iob_valid_i : s0_iob_valid_i;
      end else if (s0_iob_valid_i && s1_iob_valid_i) begin
         w_grant = ~r_last_grant;
         w_any   = 1'b1;
      end else if (s1_iob_valid_i) begin
         w_grant = 1'b1;
         w_any   = 1'b1;
      end else begin
         w_grant = 1'b0;
         w_any   = s0_iob_valid_i;
      end
   end

   always_comb begin
      m_iob_addr_o  = w_grant ? s1_iob_addr_i  : s0_iob_addr_i;
      m_iob_wdata_o = w_grant ? s1_iob_wdata_i : s0_iob_wdata_i;
      m_iob_wstrb_o = w_grant ? s1_iob_wstrb_i : s0_iob_wstrb_i;
   end

   // A read is held back only on the registered full flag, so a same-cycle
   // pop never creates an rvalid-to-valid combinational path.
   assign w_fifo_full  = (r_count == FULL_CNT);
   assign w_fifo_empty = (r_count == '0);
   assign w_is_read    = (m_iob_wstrb_o == '0);
   assign w_block      = w_is_read && w_fifo_full;
   assign w_m_valid    = w_any && !w_block;
   assign w_accept     = w_m_valid && m_iob_ready_i;

   assign m_iob_valid_o  = w_m_valid;
   assign s0_iob_ready_o = w_accept && !w_grant;
   assign s1_iob_ready_o = w_accept && w_grant;

   assign w_push = w_accept && w_is_read;
   assign w_pop  = m_iob_rvalid_i && !w_fifo_empty;
   assign w_head = r_id_mem[r_rptr];

   always_ff @(posedge clk_i) begin
      if (cke_i && w_push) begin
         r_id_mem[r_wptr] <= w_grant;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_err   <= 1'b0;
      end else if (cke_i) begin
         if (w_push) begin
            r_wptr <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
         // Stray response with nothing outstanding
         if (m_iob_rvalid_i && w_fifo_empty) begin
            r_err <= 1'b1;
         end
      end
   end

   assign w_rv0 = w_pop && !w_head;
   assign w_rv1 = w_pop && w_head;

   assign s0_iob_rvalid_o = w_rv0;
   assign s1_iob_rvalid_o = w_rv1;
   assign s0_iob_rdata_o  = w_rv0 ? m_iob_rdata_i : '0;
   assign s1_iob_rdata_o  = w_rv1 ? m_iob_rdata_i : '0;

   assign pending_o = r_count;
   assign err_o     = r_err;

endmodule

// File: tb/tb_iob_cache_iob_arbiter.sv
// Randomized and directed bench for iob_cache_iob_arbiter against a
// queue-based reference model of grant, lock and response routing.
module tb_iob_cache_iob_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int PEND_W = 2;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic cke_i, arst_i;
  logic s0_iob_valid_i, s1_iob_valid_i;
  logic [ADDR_W-1:0] s0_iob_addr_i, s1_iob_addr_i;
  logic [DATA_W-1:0] s0_iob_wdata_i, s1_iob_wdata_i;
  logic [3:0] s0_iob_wstrb_i, s1_iob_wstrb_i;
  logic s0_iob_ready_o, s1_iob_ready_o, s0_iob_rvalid_o, s1_iob_rvalid_o;
  logic [DATA_W-1:0] s0_iob_rdata_o, s1_iob_rdata_o;
  logic m_iob_valid_o;
  logic [ADDR_W-1:0] m_iob_addr_o;
  logic [DATA_W-1:0] m_iob_wdata_o;
  logic [3:0] m_iob_wstrb_o;
  logic m_iob_ready_i, m_iob_rvalid_i;
  logic [DATA_W-1:0] m_iob_rdata_i;
  logic [PEND_W:0] pending_o;
  logic err_o;
  logic [1:0] dbg_state_o;

  iob_cache_iob_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .PEND_W(PEND_W)) dut (
    .clk_i(clk), .cke_i(cke_i), .arst_i(arst_i),
    .s0_iob_valid_i(s0_iob_valid_i), .s0_iob_addr_i(s0_iob_addr_i),
    .s0_iob_wdata_i(s0_iob_wdata_i), .s0_iob_wstrb_i(s0_iob_wstrb_i),
    .s0_iob_ready_o(s0_iob_ready_o), .s0_iob_rvalid_o(s0_iob_rvalid_o),
    .s0_iob_rdata_o(s0_iob_rdata_o),
    .s1_iob_valid_i(s1_iob_valid_i), .s1_iob_addr_i(s1_iob_addr_i),
    .s1_iob_wdata_i(s1_iob_wdata_i), .s1_iob_wstrb_i(s1_iob_wstrb_i),
    .s1_iob_ready_o(s1_iob_ready_o), .s1_iob_rvalid_o(s1_iob_rvalid_o),
    .s1_iob_rdata_o(s1_iob_rdata_o),
    .m_iob_valid_o(m_iob_valid_o), .m_iob_addr_o(m_iob_addr_o),
    .m_iob_wdata_o(m_iob_wdata_o), .m_iob_wstrb_o(m_iob_wstrb_o),
    .m_iob_ready_i(m_iob_ready_i), .m_iob_rvalid_i(m_iob_rvalid_i),
    .m_iob_rdata_i(m_iob_rdata_i),
    .pending_o(pending_o), .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [0:0] exp_q[$];
  logic mdl_last, mdl_locked, mdl_owner, mdl_err;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mdl_last = 1'b1;
    mdl_locked = 1'b0;
    mdl_owner = 1'b0;
    mdl_err = 1'b0;
  endtask

  task automatic idle_inputs();
    s0_iob_valid_i = 0; s0_iob_addr_i = '0; s0_iob_wdata_i = '0; s0_iob_wstrb_i = '0;
    s1_iob_valid_i = 0; s1_iob_addr_i = '0; s1_iob_wdata_i = '0; s1_iob_wstrb_i = '0;
    m_iob_ready_i = 0; m_iob_rvalid_i = 0; m_iob_rdata_i = '0;
    cke_i = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst_i = 1;
    #2;
    model_reset();
    check_val("rst_pending", 64'(pending_o), 0);
    check_val("rst_err", 64'(err_o), 0);
    @(negedge clk);
    arst_i = 0;
    @(posedge clk);
    #1;
  endtask

  // One clock: check combinational outputs at negedge, advance the model at posedge.
  task automatic step(output logic [1:0] acc);
    logic g, any, rd, mv, accb, rv, h, ck, rvin;
    logic [3:0] ws;
    @(negedge clk);
    if (mdl_locked) begin
      g = mdl_owner; any = g ? s1_iob_valid_i : s0_iob_valid_i;
    end else if (s0_iob_valid_i && s1_iob_valid_i) begin
      g = ~mdl_last; any = 1;
    end else if (s1_iob_valid_i) begin
      g = 1; any = 1;
    end else begin
      g = 0; any = s0_iob_valid_i;
    end
    ws = g ? s1_iob_wstrb_i : s0_iob_wstrb_i;
    rd = (ws == 0);
    mv = any && !(rd && exp_q.size() == DEPTH);
    accb = mv && m_iob_ready_i;
    check_val("m_valid", 64'(m_iob_valid_o), 64'(mv));
    if (any) begin
      check_val("m_addr", 64'(m_iob_addr_o), 64'(g ? s1_iob_addr_i : s0_iob_addr_i));
      check_val("m_wdata", 64'(m_iob_wdata_o), 64'(g ? s1_iob_wdata_i : s0_iob_wdata_i));
      check_val("m_wstrb", 64'(m_iob_wstrb_o), 64'(ws));
    end
    check_val("s0_ready", 64'(s0_iob_ready_o), 64'(accb && !g));
    check_val("s1_ready", 64'(s1_iob_ready_o), 64'(accb && g));
    rv = m_iob_rvalid_i && exp_q.size() > 0;
    h = rv ? exp_q[0] : 1'b0;
    check_val("s0_rvalid", 64'(s0_iob_rvalid_o), 64'(rv && !h));
    check_val("s1_rvalid", 64'(s1_iob_rvalid_o), 64'(rv && h));
    check_val("s0_rdata", 64'(s0_iob_rdata_o), (rv && !h) ? 64'(m_iob_rdata_i) : 64'd0);
    check_val("s1_rdata", 64'(s1_iob_rdata_o), (rv && h) ? 64'(m_iob_rdata_i) : 64'd0);
    acc = {accb && g, accb && !g};
    ck = cke_i;
    rvin = m_iob_rvalid_i;
    @(posedge clk);
    #1;
    if (ck) begin
      if (rvin) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        else mdl_err = 1'b1;
      end
      if (accb && rd) exp_q.push_back(g);
      if (mv && !m_iob_ready_i) begin
        mdl_locked = 1'b1; mdl_owner = g;
      end
      if (accb) begin
        mdl_locked = 1'b0; mdl_last = g;
      end
    end
    check_val("pending", 64'(pending_o), 64'(exp_q.size()));
    check_val("err", 64'(err_o), 64'(mdl_err));
  endtask

  task automatic new_req(output logic v, output logic [ADDR_W-1:0] a,
                         output logic [DATA_W-1:0] d, output logic [3:0] s);
    v = ($urandom_range(0, 2) != 0);
    a = $urandom;
    d = $urandom;
    s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
  endtask

  logic [1:0] acc;
  logic [0:0] grant_log[$];

  initial begin
    arst_i = 0;
    idle_inputs();
    model_reset();
    do_reset();

    // single read from s0, response one cycle later
    s0_iob_valid_i = 1; s0_iob_addr_i = 32'h10; s0_iob_wstrb_i = 0; m_iob_ready_i = 1;
    step(acc);
    check_val("t1_acc", 64'(acc), 64'b01);
    check_val("t1_pend1", 64'(pending_o), 1);
    s0_iob_valid_i = 0; m_iob_ready_i = 0;
    m_iob_rvalid_i = 1; m_iob_rdata_i = 32'hDEADBEEF;
    step(acc);
    m_iob_rvalid_i = 0;
    check_val("t1_pend0", 64'(pending_o), 0);

    // continuous contention alternates s0, s1, ...
    do_reset();
    s0_iob_valid_i = 1; s0_iob_wstrb_i = 4'hF; s0_iob_addr_i = 32'h100;
    s1_iob_valid_i = 1; s1_iob_wstrb_i = 4'hF; s1_iob_addr_i = 32'h200;
    m_iob_ready_i = 1;
    for (int k = 0; k < 6; k++) begin
      step(acc);
      check_val("t2_alt", 64'(acc), (k % 2 == 0) ? 64'b01 : 64'b10);
    end

    // stall holds grant on s0
    do_reset();
    s1_iob_valid_i = 0; s0_iob_valid_i = 1; m_iob_ready_i = 0;
    for (int k = 0; k < 3; k++) begin
      step(acc);
      check_val("t3_stall", 64'(acc), 0);
      s1_iob_valid_i = 1;
    end
    m_iob_ready_i = 1;
    step(acc);
    check_val("t3_s0", 64'(acc), 64'b01);
    s0_iob_valid_i = 0;
    step(acc);
    check_val("t3_s1", 64'(acc), 64'b10);

    // fill the ID FIFO, block a read, let a write pass, drain
    do_reset();
    s0_iob_valid_i = 1; s0_iob_wstrb_i = 0; s1_iob_valid_i = 1; s1_iob_wstrb_i = 0;
    for (int k = 0; k < 4; k++) begin
      s0_iob_addr_i = 32'(k * 8); s1_iob_addr_i = 32'(k * 8 + 4);
      step(acc);
    end
    check_val("t4_full", 64'(pending_o), 4);
    s0_iob_valid_i = 0; s1_iob_wstrb_i = 4'h3;
    step(acc);
    check_val("t4_wr_pass", 64'(acc), 64'b10);
    s1_iob_valid_i = 0; s0_iob_valid_i = 1;
    step(acc);
    check_val("t4_rd_block", 64'(acc), 0);
    s0_iob_valid_i = 0;
    for (int k = 0; k < 4; k++) begin
      m_iob_rvalid_i = 1; m_iob_rdata_i = $urandom;
      step(acc);
    end
    m_iob_rvalid_i = 0;
    check_val("t4_drain", 64'(pending_o), 0);

    // read accepted in the same cycle as an earlier response
    do_reset();
    s0_iob_valid_i = 1; s0_iob_wstrb_i = 0; s0_iob_addr_i = 32'h40;
    step(acc);
    s0_iob_valid_i = 0; s1_iob_valid_i = 1; s1_iob_wstrb_i = 4'hF;
    step(acc);
    s1_iob_valid_i = 0; s0_iob_valid_i = 1; s0_iob_addr_i = 32'h44;
    m_iob_rvalid_i = 1; m_iob_rdata_i = 32'h12345678;
    step(acc);
    check_val("t5_pend", 64'(pending_o), 1);
    s0_iob_valid_i = 0; m_iob_rvalid_i = 1; m_iob_rdata_i = 32'hCAFEF00D;
    step(acc);
    m_iob_rvalid_i = 0;

    // stray response sets the sticky error
    idle_inputs();
    m_iob_rvalid_i = 1; m_iob_rdata_i = 32'h55;
    step(acc);
    m_iob_rvalid_i = 0;
    check_val("t6_err", 64'(err_o), 1);
    for (int k = 0; k < 3; k++) step(acc);
    check_val("t6_sticky", 64'(err_o), 1);
    do_reset();
    check_val("t6_cleared", 64'(err_o), 0);

    // randomized traffic with occasional mid-run reset
    idle_inputs();
    for (int n = 0; n < 3000; n++) begin
      cke_i = ($urandom_range(0, 9) != 0);
      m_iob_ready_i = ($urandom_range(0, 2) != 0);
      m_iob_rdata_i = $urandom;
      m_iob_rvalid_i = (exp_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                          : ($urandom_range(0, 199) == 0);
      step(acc);
      if (!s0_iob_valid_i || acc[0])
        new_req(s0_iob_valid_i, s0_iob_addr_i, s0_iob_wdata_i, s0_iob_wstrb_i);
      if (!s1_iob_valid_i || acc[1])
        new_req(s1_iob_valid_i, s1_iob_addr_i, s1_iob_wdata_i, s1_iob_wstrb_i);
      if (n % 1000 == 999) begin
        idle_inputs();
        do_reset();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
